decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/riscv_pkg.sv | 58 +++++
 rtl/imm_gen.sv | 26 ++
 rtl/decode_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared RV32 decode constants: major opcodes, funct7 patterns, ALU_Control
//   groups and codes, op_A_sel codes, and the immediate-format classifier used
//   by both the decoder and imm_gen.
package riscv_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 patterns that change the ALU group
  localparam logic [6:0] F7_ALT    = 7'b0100000;  // SUB / SRA / SRAI
  localparam logic [6:0] F7_MULDIV = 7'b0000001;  // RV32M

  // ALU_Control = {group, funct3} for arithmetic; fixed codes otherwise
  localparam logic [2:0] ALU_GRP_BASE = 3'b000;
  localparam logic [2:0] ALU_GRP_M    = 3'b001;
  localparam logic [2:0] ALU_GRP_ALT  = 3'b010;
  localparam logic [5:0] ALU_ADD      = 6'b000000;  // address / LUI / AUIPC add
  localparam logic [5:0] ALU_LINK     = 6'b011111;  // JAL/JALR pass-through of PC+4

  // op_A_sel codes
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_PC4  = 2'b10;
  localparam logic [1:0] OPA_ZERO = 2'b11;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // Immediate format selected purely by opcode; R-type and unknown give none.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                      fmt = FMT_S;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      default:                        fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen
//   Combinational immediate generator: builds the sign-extended 32-bit
//   immediate for the I/S/B/U/J format implied by the opcode, 0 otherwise.
// Ports:
//   instr  in  32  instruction word
//   imm32  out 32  sign-extended immediate
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm32
);

  always_comb begin
    imm32 = 32'b0;
    case (imm_fmt(instr[6:0]))
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'b0;
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe
//   RV32I(+optional M) decode stage with a valid/ready handshake on both
//   sides. The decoded bundle is registered (1-cycle latency). Detects a
//   load-use hazard against the bundle held for execute and inserts one
//   bubble; a captured JAL raises a one-cycle redirect with its target.
// Ports:
//   clock, reset (sync, active-low)
//   if_valid/if_ready, PC, instr     fetch side
//   flush                            execute mispredict kill
//   ex_valid/ex_ready, ex_PC         execute side handshake and bundle PC
//   read_sel1/2, write_sel, wEn, mem_wEn, wb_sel, op_A_sel, op_B_sel,
//   ALU_Control, imm32, branch_op, illegal   decoded bundle
//   next_PC_select, target_PC        JAL redirect
module decode_pipe
  import riscv_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter bit ENABLE_M     = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_valid,
  output logic                    if_ready,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instr,
  input  logic                    flush,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [ADDRESS_BITS-1:0] ex_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic [31:0]             imm32,
  output logic                    branch_op,
  output logic                    illegal,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  logic [31:0] imm32_next;

  imm_gen u_imm_gen (
    .instr (instr),
    .imm32 (imm32_next)
  );

  logic       w_en_next;
  logic       mem_w_en_next;
  logic       wb_sel_next;
  logic [1:0] op_a_sel_next;
  logic       op_b_sel_next;
  logic [5:0] alu_control_next;
  logic       branch_op_next;
  logic       illegal_next;
  logic       rs1_used;
  logic       rs2_used;

  always_comb begin
    w_en_next        = 1'b0;
    mem_w_en_next    = 1'b0;
    wb_sel_next      = 1'b0;
    op_a_sel_next    = OPA_RS1;
    op_b_sel_next    = 1'b0;
    alu_control_next = {ALU_GRP_BASE, funct3};
    branch_op_next   = 1'b0;
    illegal_next     = 1'b0;
    rs1_used         = 1'b0;
    rs2_used         = 1'b0;

    case (opcode)
      OPC_OP: begin
        w_en_next     = 1'b1;
        op_b_sel_next = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M) alu_control_next = {ALU_GRP_M, funct3};
          else          illegal_next     = 1'b1;
        end else if (funct7 == F7_ALT) begin
          alu_control_next = {ALU_GRP_ALT, funct3};
        end
      end
      OPC_OP_IMM: begin
        w_en_next = 1'b1;
        rs1_used  = 1'b1;
        // Only SRAI uses funct7 to pick the alternate op; other I-types
        // carry immediate bits there.
        if (funct3 == 3'b101 && funct7 == F7_ALT)
          alu_control_next = {ALU_GRP_ALT, funct3};
      end
      OPC_LOAD: begin
        w_en_next        = 1'b1;
        wb_sel_next      = 1'b1;
        alu_control_next = ALU_ADD;
        rs1_used         = 1'b1;
      end
      OPC_STORE: begin
        mem_w_en_next    = 1'b1;
        alu_control_next = ALU_ADD;
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OPC_BRANCH: begin
        branch_op_next   = 1'b1;
        op_b_sel_next    = 1'b1;
        alu_control_next = {ALU_GRP_ALT, funct3};
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OPC_LUI: begin
        w_en_next        = 1'b1;
        op_a_sel_next    = OPA_ZERO;
        alu_control_next = ALU_ADD;
      end
      OPC_AUIPC: begin
        w_en_next        = 1'b1;
        op_a_sel_next    = OPA_PC;
        alu_control_next = ALU_ADD;
      end
      OPC_JAL: begin
        w_en_next        = 1'b1;
        op_a_sel_next    = OPA_PC4;
        alu_control_next = ALU_LINK;
      end
      OPC_JALR: begin
        w_en_next        = 1'b1;
        op_a_sel_next    = OPA_PC4;
        alu_control_next = ALU_LINK;
        rs1_used         = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase

    // An illegal encoding must not cause any architectural side effect.
    if (illegal_next) begin
      w_en_next      = 1'b0;
      mem_w_en_next  = 1'b0;
      branch_op_next = 1'b0;
    end
  end

  // Load-use: the held bundle is a load (wb_sel) whose rd feeds the incoming
  // instruction, so the incoming one must wait one cycle.
  logic hazard;
  logic transfer;
  logic is_jal;

  assign hazard = ex_valid && wb_sel && (write_sel != 5'd0) &&
                  ((rs1_used && (rs1 == write_sel)) ||
                   (rs2_used && (rs2 == write_sel)));

  assign if_ready = reset && (!ex_valid || ex_ready) && !hazard &&
                    !flush && !next_PC_select;
  assign transfer = if_valid && if_ready;
  assign is_jal   = (opcode == OPC_JAL);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_valid       <= 1'b0;
      ex_PC          <= '0;
      read_sel1      <= 5'd0;
      read_sel2      <= 5'd0;
      write_sel      <= 5'd0;
      wEn            <= 1'b0;
      mem_wEn        <= 1'b0;
      wb_sel         <= 1'b0;
      op_A_sel       <= 2'b00;
      op_B_sel       <= 1'b0;
      ALU_Control    <= 6'd0;
      imm32          <= 32'd0;
      branch_op      <= 1'b0;
      illegal        <= 1'b0;
      next_PC_select <= 1'b0;
      target_PC      <= '0;
    end else if (flush) begin
      ex_valid       <= 1'b0;
      next_PC_select <= 1'b0;
    end else begin
      next_PC_select <= 1'b0;
      if (transfer) begin
        ex_valid    <= 1'b1;
        ex_PC       <= PC;
        read_sel1   <= rs1;
        read_sel2   <= rs2;
        write_sel   <= rd;
        wEn         <= w_en_next;
        mem_wEn     <= mem_w_en_next;
        wb_sel      <= wb_sel_next;
        op_A_sel    <= op_a_sel_next;
        op_B_sel    <= op_b_sel_next;
        ALU_Control <= alu_control_next;
        imm32       <= imm32_next;
        branch_op   <= branch_op_next;
        illegal     <= illegal_next;
        if (is_jal) begin
          next_PC_select <= 1'b1;
          // Truncating add gives the target modulo 2^ADDRESS_BITS.
          target_PC      <= PC + imm32_next[ADDRESS_BITS-1:0];
        end
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        if_valid;
  logic        flush;
  logic        ex_ready;
  logic [15:0] PC;
  logic [31:0] instr;

  // ENABLE_M = 0 instance
  logic        if_ready, ex_valid, wEn, mem_wEn, wb_sel, op_B_sel, branch_op, illegal, next_PC_select;
  logic [15:0] ex_PC, target_PC;
  logic [4:0]  read_sel1, read_sel2, write_sel;
  logic [1:0]  op_A_sel;
  logic [5:0]  ALU_Control;
  logic [31:0] imm32;

  // ENABLE_M = 1 instance
  logic        m_if_ready, m_ex_valid, m_wEn, m_mem_wEn, m_wb_sel, m_op_B_sel, m_branch_op, m_illegal, m_next_PC_select;
  logic [15:0] m_ex_PC, m_target_PC;
  logic [4:0]  m_read_sel1, m_read_sel2, m_write_sel;
  logic [1:0]  m_op_A_sel;
  logic [5:0]  m_ALU_Control;
  logic [31:0] m_imm32;

  decode_pipe #(.ADDRESS_BITS(16), .ENABLE_M(1'b0)) dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .PC(PC), .instr(instr), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_PC(ex_PC), .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
    .wEn(wEn), .mem_wEn(mem_wEn), .wb_sel(wb_sel), .op_A_sel(op_A_sel), .op_B_sel(op_B_sel),
    .ALU_Control(ALU_Control), .imm32(imm32), .branch_op(branch_op), .illegal(illegal),
    .next_PC_select(next_PC_select), .target_PC(target_PC)
  );

  decode_pipe #(.ADDRESS_BITS(16), .ENABLE_M(1'b1)) dut_m (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_ready(m_if_ready),
    .PC(PC), .instr(instr), .flush(flush), .ex_valid(m_ex_valid), .ex_ready(ex_ready),
    .ex_PC(m_ex_PC), .read_sel1(m_read_sel1), .read_sel2(m_read_sel2), .write_sel(m_write_sel),
    .wEn(m_wEn), .mem_wEn(m_mem_wEn), .wb_sel(m_wb_sel), .op_A_sel(m_op_A_sel), .op_B_sel(m_op_B_sel),
    .ALU_Control(m_ALU_Control), .imm32(m_imm32), .branch_op(m_branch_op), .illegal(m_illegal),
    .next_PC_select(m_next_PC_select), .target_PC(m_target_PC)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction, confirm the stage is ready, and let it transfer.
  // Returns 1 time unit after the capturing edge with if_valid dropped.
  task automatic issue(input logic [15:0] pc, input logic [31:0] ins, input string name);
    if_valid = 1'b1;
    PC       = pc;
    instr    = ins;
    #1;
    check({name, "_if_ready"}, 32'(if_ready), 32'd1);
    @(posedge clock);
    #1;
    if_valid = 1'b0;
    $display("txn %s pc=%h instr=%h -> ex_valid=%0b alu=%b imm=%h wEn=%0b ill=%0b",
             name, pc, ins, ex_valid, ALU_Control, imm32, wEn, illegal);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A103;  // lw x2,0(x1)
  localparam logic [31:0] I_ADD  = 32'h001101B3;  // add x3,x2,x1
  localparam logic [31:0] I_SW   = 32'hFE20AE23;  // sw x2,-4(x1)
  localparam logic [31:0] I_BNE  = 32'hFE209CE3;  // bne x1,x2,-8
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui x5,0x12345
  localparam logic [31:0] I_AUI  = 32'h00001317;  // auipc x6,1
  localparam logic [31:0] I_SRAI = 32'h4030D393;  // srai x7,x1,3
  localparam logic [31:0] I_JALR = 32'h004100E7;  // jalr x1,4(x2)
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;  // unknown opcode
  localparam logic [31:0] I_ADD0 = 32'h00100013;  // addi x0,x0,1
  localparam logic [31:0] I_MUL  = 32'h022081B3;  // mul x3,x1,x2
  localparam logic [31:0] I_JAL  = 32'h008000EF;  // jal x1,+8

  initial begin
    reset    = 1'b0;
    if_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    PC       = 16'h0;
    instr    = 32'h0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_npc", 32'(next_PC_select), 32'd0);
    check("rst_wEn", 32'(wEn), 32'd0);
    check("rst_alu", 32'(ALU_Control), 32'd0);
    check("rst_imm", imm32, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b1;

    // addi
    issue(16'h0010, I_ADDI, "addi");
    check("addi_ex_valid", 32'(ex_valid), 32'd1);
    check("addi_write_sel", 32'(write_sel), 32'd1);
    check("addi_imm", imm32, 32'd5);
    check("addi_alu", 32'(ALU_Control), 32'h00);
    check("addi_op_b", 32'(op_B_sel), 32'd0);
    check("addi_wEn", 32'(wEn), 32'd1);
    check("addi_ex_pc", 32'(ex_PC), 32'h0010);
    check("addi_op_a", 32'(op_A_sel), 32'd0);

    // sub
    issue(16'h0014, I_SUB, "sub");
    check("sub_alu", 32'(ALU_Control), 32'h10);
    check("sub_op_b", 32'(op_B_sel), 32'd1);
    check("sub_wEn", 32'(wEn), 32'd1);
    check("sub_rs1", 32'(read_sel1), 32'd1);
    check("sub_rs2", 32'(read_sel2), 32'd2);
    check("sub_rd", 32'(write_sel), 32'd3);
    check("sub_imm", imm32, 32'd0);

    // lw then dependent add: one bubble
    issue(16'h0018, I_LW, "lw");
    check("lw_wb_sel", 32'(wb_sel), 32'd1);
    check("lw_rd", 32'(write_sel), 32'd2);
    check("lw_mem_wEn", 32'(mem_wEn), 32'd0);
    if_valid = 1'b1;
    PC       = 16'h001C;
    instr    = I_ADD;
    #1;
    check("hz_if_ready", 32'(if_ready), 32'd0);
    @(posedge clock);
    #1;
    check("hz_bubble", 32'(ex_valid), 32'd0);
    check("hz_if_ready_after", 32'(if_ready), 32'd1);
    @(posedge clock);
    #1;
    if_valid = 1'b0;
    $display("txn add-after-lw pc=001c ex_valid=%0b ex_PC=%h", ex_valid, ex_PC);
    check("hz_add_valid", 32'(ex_valid), 32'd1);
    check("hz_add_pc", 32'(ex_PC), 32'h001C);
    check("hz_add_rd", 32'(write_sel), 32'd3);
    check("hz_add_rs1", 32'(read_sel1), 32'd2);

    // lw then independent addi: no bubble (readiness checked in issue)
    issue(16'h0020, I_LW, "lw2");
    issue(16'h0024, I_ADDI, "addi_nohz");
    check("nohz_pc", 32'(ex_PC), 32'h0024);

    // store with negative offset
    issue(16'h0028, I_SW, "sw");
    check("sw_mem_wEn", 32'(mem_wEn), 32'd1);
    check("sw_wEn", 32'(wEn), 32'd0);
    check("sw_imm", imm32, 32'hFFFFFFFC);
    check("sw_op_b", 32'(op_B_sel), 32'd0);

    // ex_ready with nothing new: bundle retires
    @(posedge clock);
    #1;
    check("drain_ex_valid", 32'(ex_valid), 32'd0);

    issue(16'h002C, I_BNE, "bne");
    check("bne_branch", 32'(branch_op), 32'd1);
    check("bne_wEn", 32'(wEn), 32'd0);
    check("bne_alu", 32'(ALU_Control), 32'h11);
    check("bne_imm", imm32, 32'hFFFFFFF8);
    check("bne_op_b", 32'(op_B_sel), 32'd1);

    issue(16'h0030, I_LUI, "lui");
    check("lui_op_a", 32'(op_A_sel), 32'd3);
    check("lui_imm", imm32, 32'h12345000);
    check("lui_rd", 32'(write_sel), 32'd5);
    check("lui_alu", 32'(ALU_Control), 32'h00);

    issue(16'h0034, I_AUI, "auipc");
    check("auipc_op_a", 32'(op_A_sel), 32'd1);
    check("auipc_imm", imm32, 32'h00001000);

    issue(16'h0038, I_SRAI, "srai");
    check("srai_alu", 32'(ALU_Control), 32'h15);
    check("srai_rd", 32'(write_sel), 32'd7);

    issue(16'h003C, I_JALR, "jalr");
    check("jalr_alu", 32'(ALU_Control), 32'h1F);
    check("jalr_op_a", 32'(op_A_sel), 32'd2);
    check("jalr_imm", imm32, 32'd4);
    check("jalr_npc", 32'(next_PC_select), 32'd0);

    issue(16'h0040, I_BAD, "bad");
    check("bad_illegal", 32'(illegal), 32'd1);
    check("bad_wEn", 32'(wEn), 32'd0);
    check("bad_mem_wEn", 32'(mem_wEn), 32'd0);
    check("bad_branch", 32'(branch_op), 32'd0);

    issue(16'h0044, I_ADD0, "addi_x0");
    check("x0_rd", 32'(write_sel), 32'd0);
    check("x0_wEn", 32'(wEn), 32'd1);

    issue(16'h0048, I_MUL, "mul");
    check("mul_noM_illegal", 32'(illegal), 32'd1);
    check("mul_noM_wEn", 32'(wEn), 32'd0);
    check("mul_M_alu", 32'(m_ALU_Control), 32'h08);
    check("mul_M_illegal", 32'(m_illegal), 32'd0);
    check("mul_M_wEn", 32'(m_wEn), 32'd1);

    // JAL redirect
    issue(16'h0100, I_JAL, "jal");
    check("jal_valid", 32'(ex_valid), 32'd1);
    check("jal_npc", 32'(next_PC_select), 32'd1);
    check("jal_target", 32'(target_PC), 32'h0108);
    check("jal_alu", 32'(ALU_Control), 32'h1F);
    check("jal_op_a", 32'(op_A_sel), 32'd2);
    check("jal_rd", 32'(write_sel), 32'd1);
    check("jal_imm", imm32, 32'd8);
    if_valid = 1'b1;
    PC       = 16'h0108;
    instr    = I_ADDI;
    #1;
    check("jal_if_ready", 32'(if_ready), 32'd0);
    @(posedge clock);
    #1;
    check("jal_npc_clear", 32'(next_PC_select), 32'd0);
    check("jal_no_xfer", 32'(ex_valid), 32'd0);
    issue(16'h0108, I_ADDI, "addi_tgt");
    check("tgt_pc", 32'(ex_PC), 32'h0108);

    // JAL target wraps modulo 2^16
    issue(16'hFFFC, I_JAL, "jal_wrap");
    check("wrap_target", 32'(target_PC), 32'h0004);
    @(posedge clock);
    #1;
    check("wrap_npc_clear", 32'(next_PC_select), 32'd0);

    // Stall three cycles, then flush
    issue(16'h0200, I_ADDI, "addi_stall");
    ex_ready = 1'b0;
    if_valid = 1'b1;
    PC       = 16'h0204;
    instr    = I_SUB;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_if_ready", 32'(if_ready), 32'd0);
      @(posedge clock);
      #1;
      check("stall_valid", 32'(ex_valid), 32'd1);
      check("stall_pc", 32'(ex_PC), 32'h0200);
      check("stall_rd", 32'(write_sel), 32'd1);
      check("stall_imm", imm32, 32'd5);
      check("stall_alu", 32'(ALU_Control), 32'h00);
    end
    flush = 1'b1;
    #1;
    check("flush_if_ready", 32'(if_ready), 32'd0);
    @(posedge clock);
    #1;
    $display("txn flush ex_valid=%0b", ex_valid);
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    flush    = 1'b0;
    ex_ready = 1'b1;
    if_valid = 1'b0;

    // Reset mid-operation discards the bundle
    issue(16'h0300, I_SUB, "sub_pre_rst");
    reset    = 1'b0;
    if_valid = 1'b1;
    instr    = I_ADDI;
    #1;
    check("rst2_if_ready", 32'(if_ready), 32'd0);
    @(posedge clock);
    #1;
    $display("txn reset ex_valid=%0b", ex_valid);
    check("rst2_ex_valid", 32'(ex_valid), 32'd0);
    check("rst2_wEn", 32'(wEn), 32'd0);
    check("rst2_rd", 32'(write_sel), 32'd0);
    check("rst2_alu", 32'(ALU_Control), 32'd0);
    check("rst2_pc", 32'(ex_PC), 32'd0);
    if_valid = 1'b0;
    reset    = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
